// File: rtl/alu_op_sequencer.sv
// EX-stage ALU control: decodes RV32I R/I-type and M-extension ops into a registered
// Operation code and sequences multi-cycle MUL/DIV with a stall/done handshake.
module alu_op_sequencer #(
   parameter int OP_W    = 5,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33,
   parameter int M_EXT   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic            flush,
   input  logic [1:0]      ALUOp,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   output logic [OP_W-1:0] Operation,
   output logic            op_valid,
   output logic            stall,
   output logic            op_done,
   output logic            is_muldiv,
   output logic            illegal
);

   localparam int CNT_W = $clog2(DIV_LAT);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [4:0] OP_AND  = 5'b00000;
   localparam logic [4:0] OP_OR   = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00010;
   localparam logic [4:0] OP_XOR  = 5'b00011;
   localparam logic [4:0] OP_SLL  = 5'b00100;
   localparam logic [4:0] OP_SRL  = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SRA  = 5'b00111;
   localparam logic [4:0] OP_SLT  = 5'b01000;
   localparam logic [4:0] OP_SLTU = 5'b01001;
   localparam logic [4:0] OP_BLT  = 5'b01111;

   // cnt is loaded with LAT-1; op_done fires once it reaches zero.
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       op_q, op_d;
   logic             md_q, md_d;
   logic             ill_q, ill_d;

   logic [4:0]       dec_op;
   logic             dec_md;
   logic             dec_ill;
   logic [CNT_W-1:0] dec_cnt;
   logic             f75_eff;
   logic             busy;
   logic             can_accept;

   // I-type immediates have no SUB; bit 30 only matters for the SRAI/SRLI split.
   assign f75_eff = (ALUOp == 2'b11 && funct3 != 3'b101) ? 1'b0 : funct7_5;

   always_comb begin
      dec_op  = OP_AND;
      dec_md  = 1'b0;
      dec_ill = 1'b0;
      dec_cnt = '0;
      case (ALUOp)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = (funct3 == 3'b100) ? OP_BLT : OP_SUB;
         default: begin
            if (ALUOp == 2'b10 && funct7_0) begin
               if (M_EXT != 0) begin
                  dec_op  = {2'b10, funct3};
                  dec_md  = 1'b1;
                  dec_cnt = funct3[2] ? DIV_CNT : MUL_CNT;
               end else begin
                  dec_ill = 1'b1;
               end
            end else begin
               case ({f75_eff, funct3})
                  4'b0000: dec_op = OP_ADD;
                  4'b1000: dec_op = OP_SUB;
                  4'b0111: dec_op = OP_AND;
                  4'b0110: dec_op = OP_OR;
                  4'b0100: dec_op = OP_XOR;
                  4'b0001: dec_op = OP_SLL;
                  4'b0101: dec_op = OP_SRL;
                  4'b1101: dec_op = OP_SRA;
                  4'b0010: dec_op = OP_SLT;
                  4'b0011: dec_op = OP_SLTU;
                  default: dec_ill = 1'b1;
               endcase
            end
         end
      endcase
   end

   assign busy       = (state_q == S_BUSY);
   assign can_accept = !busy || (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      md_d    = md_q;
      ill_d   = ill_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (can_accept) begin
         if (valid_in) begin
            state_d = S_BUSY;
            cnt_d   = dec_cnt;
            op_d    = dec_op;
            md_d    = dec_md;
            ill_d   = dec_ill;
         end else begin
            state_d = S_IDLE;
         end
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         md_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         md_q    <= md_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      Operation      = '0;
      Operation[4:0] = op_q;
   end

   assign op_valid  = busy;
   assign op_done   = busy && (cnt_q == '0);
   assign stall     = busy && (cnt_q != '0);
   assign is_muldiv = md_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: default M-enabled instance plus an M_EXT=0 instance
// sharing the same stimulus.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset, valid_in, flush;
   logic [1:0] ALUOp;
   logic [2:0] funct3;
   logic       funct7_5, funct7_0;

   logic [4:0] op_m;
   logic       vld_m, stall_m, done_m, md_m, ill_m;
   logic [4:0] op_n;
   logic       vld_n, stall_n, done_n, md_n, ill_n;

   int checks = 0;
   int errors = 0;
   logic seen_done;

   always #5 clk = ~clk;

   alu_op_sequencer #(.OP_W(5), .MUL_LAT(3), .DIV_LAT(33), .M_EXT(1)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
      .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
      .Operation(op_m), .op_valid(vld_m), .stall(stall_m), .op_done(done_m),
      .is_muldiv(md_m), .illegal(ill_m)
   );

   alu_op_sequencer #(.OP_W(5), .MUL_LAT(3), .DIV_LAT(33), .M_EXT(0)) dut_nom (
      .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
      .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
      .Operation(op_n), .op_valid(vld_n), .stall(stall_n), .op_done(done_n),
      .is_muldiv(md_n), .illegal(ill_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] aop, input logic f75,
                        input logic f70, input logic [2:0] f3);
      valid_in = v;
      ALUOp    = aop;
      funct7_5 = f75;
      funct7_0 = f70;
      funct3   = f3;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
      tick(); tick();
      chk("rst_op", 32'(op_m), 32'h0);
      chk("rst_vld", 32'(vld_m), 32'h0);
      chk("rst_stall", 32'(stall_m), 32'h0);
      chk("rst_done", 32'(done_m), 32'h0);
      chk("rst_md", 32'(md_m), 32'h0);
      chk("rst_ill", 32'(ill_m), 32'h0);
      reset = 1'b0;
      tick();

      // R-type SUB, single cycle
      drive(1'b1, 2'b10, 1'b1, 1'b0, 3'b000);
      tick();
      chk("sub_op", 32'(op_m), 32'h06);
      chk("sub_done", 32'(done_m), 32'h1);
      chk("sub_stall", 32'(stall_m), 32'h0);
      chk("sub_vld", 32'(vld_m), 32'h1);
      valid_in = 1'b0;
      tick();
      chk("idle_vld", 32'(vld_m), 32'h0);
      chk("idle_done", 32'(done_m), 32'h0);
      chk("idle_hold_op", 32'(op_m), 32'h06);

      // BLT then ADDI back to back
      drive(1'b1, 2'b01, 1'b0, 1'b0, 3'b100);
      tick();
      chk("blt_op", 32'(op_m), 32'h0F);
      chk("blt_done", 32'(done_m), 32'h1);
      drive(1'b1, 2'b11, 1'b1, 1'b0, 3'b000);
      tick();
      chk("addi_op", 32'(op_m), 32'h02);
      chk("addi_done", 32'(done_m), 32'h1);
      drive(1'b1, 2'b11, 1'b1, 1'b0, 3'b101);
      tick();
      chk("srai_op", 32'(op_m), 32'h07);
      valid_in = 1'b0;
      tick();

      // DIV, valid_in held (as ADD) through the stall
      drive(1'b1, 2'b10, 1'b0, 1'b1, 3'b100);
      tick();
      chk("div_op", 32'(op_m), 32'h14);
      chk("div_md", 32'(md_m), 32'h1);
      chk("div_stall1", 32'(stall_m), 32'h1);
      chk("div_done1", 32'(done_m), 32'h0);
      drive(1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
      for (int k = 2; k <= 32; k++) begin
         tick();
         chk("div_stall_k", 32'(stall_m), 32'h1);
         chk("div_nodone_k", 32'(done_m), 32'h0);
         chk("div_hold_op", 32'(op_m), 32'h14);
      end
      tick();
      chk("div_done33", 32'(done_m), 32'h1);
      chk("div_stall33", 32'(stall_m), 32'h0);
      chk("div_op33", 32'(op_m), 32'h14);
      tick();
      chk("div_next_op", 32'(op_m), 32'h02);
      chk("div_next_md", 32'(md_m), 32'h0);
      chk("div_next_done", 32'(done_m), 32'h1);
      valid_in = 1'b0;
      tick();

      // ADD, MUL, AND on consecutive valid cycles
      drive(1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      chk("b2b_add_op", 32'(op_m), 32'h02);
      chk("b2b_add_done", 32'(done_m), 32'h1);
      drive(1'b1, 2'b10, 1'b0, 1'b1, 3'b000);
      tick();
      chk("mul_op", 32'(op_m), 32'h10);
      chk("mul_stall1", 32'(stall_m), 32'h1);
      chk("mul_done1", 32'(done_m), 32'h0);
      drive(1'b1, 2'b10, 1'b0, 1'b0, 3'b111);
      tick();
      chk("mul_stall2", 32'(stall_m), 32'h1);
      chk("mul_done2", 32'(done_m), 32'h0);
      tick();
      chk("mul_done3", 32'(done_m), 32'h1);
      chk("mul_stall3", 32'(stall_m), 32'h0);
      chk("mul_op3", 32'(op_m), 32'h10);
      tick();
      chk("and_op", 32'(op_m), 32'h00);
      chk("and_done", 32'(done_m), 32'h1);
      chk("and_md", 32'(md_m), 32'h0);
      chk("and_ill", 32'(ill_m), 32'h0);
      valid_in = 1'b0;
      tick();

      // DIVU killed by flush in cycle T+10, with a same-cycle valid_in dropped
      drive(1'b1, 2'b10, 1'b0, 1'b1, 3'b101);
      tick();
      chk("divu_op", 32'(op_m), 32'h15);
      valid_in = 1'b0;
      for (int k = 2; k <= 10; k++) tick();
      chk("fl_pre_stall", 32'(stall_m), 32'h1);
      flush = 1'b1;
      drive(1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      flush = 1'b0;
      valid_in = 1'b0;
      chk("fl_vld", 32'(vld_m), 32'h0);
      chk("fl_stall", 32'(stall_m), 32'h0);
      chk("fl_done", 32'(done_m), 32'h0);
      seen_done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         seen_done = seen_done | done_m;
      end
      chk("fl_never_done", 32'(seen_done), 32'h0);

      // Same sequence with reset in cycle T+10
      drive(1'b1, 2'b10, 1'b0, 1'b1, 3'b100);
      tick();
      valid_in = 1'b0;
      for (int k = 2; k <= 10; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_op", 32'(op_m), 32'h0);
      chk("mr_vld", 32'(vld_m), 32'h0);
      chk("mr_stall", 32'(stall_m), 32'h0);
      chk("mr_done", 32'(done_m), 32'h0);
      chk("mr_md", 32'(md_m), 32'h0);
      chk("mr_ill", 32'(ill_m), 32'h0);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         seen_done = seen_done | done_m;
      end
      chk("mr_never_done", 32'(seen_done), 32'h0);

      // M_EXT=0 instance: funct7_0=1 R-type is illegal, single cycle
      drive(1'b1, 2'b10, 1'b0, 1'b1, 3'b000);
      tick();
      chk("nom_ill", 32'(ill_n), 32'h1);
      chk("nom_op", 32'(op_n), 32'h0);
      chk("nom_done", 32'(done_n), 32'h1);
      chk("nom_stall", 32'(stall_n), 32'h0);
      chk("nom_md", 32'(md_n), 32'h0);
      valid_in = 1'b0;
      tick(); tick(); tick();

      // Unlisted key {1,111}
      drive(1'b1, 2'b10, 1'b1, 1'b0, 3'b111);
      tick();
      chk("bad_key_ill", 32'(ill_m), 32'h1);
      chk("bad_key_op", 32'(op_m), 32'h0);
      chk("bad_key_done", 32'(done_m), 32'h1);
      drive(1'b1, 2'b10, 1'b0, 1'b0, 3'b011);
      tick();
      chk("sltu_op", 32'(op_m), 32'h09);
      chk("sltu_ill", 32'(ill_m), 32'h0);
      valid_in = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
